// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the BCD serial adder/subtractor
package bcd_pkg;

    localparam int                 BCD_W   = 4;
    localparam logic [BCD_W-1:0]   BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - combinational single-digit BCD add/subtract cell
// Ports: x, y  - BCD digits (values above 9 are processed, not rejected)
//        c     - carry-in (already inverted by the caller for subtraction)
//        sub   - 1 selects x + nines(y) + c
//        digit - BCD result digit
//        carry - decimal carry-out
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             c,
    input  logic             sub,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W-1:0] y_adj;
    logic [BCD_W:0]   t;

    always_comb begin
        // Nine's complement wraps mod 16 for out-of-range digits.
        y_adj = sub ? (BCD_MAX - y) : y;
        t     = {1'b0, x} + {1'b0, y_adj} + {{BCD_W{1'b0}}, c};
        if (t > {1'b0, BCD_MAX}) begin
            digit = t[BCD_W-1:0] + 4'd6;
            carry = 1'b1;
        end else begin
            digit = t[BCD_W-1:0];
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor, LSD first
// Ports: clk, rst_n         - clock, asynchronous active-low reset
//        start, sub, cin    - request, mode and carry/borrow-in (captured on accept)
//        a, b               - packed BCD operands, digit i at [4i+3:4i]
//        busy, done         - RUN indicator, one-cycle result-valid pulse
//        s, cout, invalid   - result, decimal carry (sub: 1 = no borrow), bad-digit flag
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic                      cin,
    input  logic [BCD_W*DIGITS-1:0]   a,
    input  logic [BCD_W*DIGITS-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   s,
    output logic                      cout,
    output logic                      invalid
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, b_q;
    logic             sub_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             last;
    logic             any_bad;
    logic [BCD_W-1:0] digit;
    logic             carry_d;
    logic [W+BCD_W-1:0] s_ins;

    // Operands shift right each RUN cycle, so the cell always sees the low nibble.
    bcd_digit_addsub u_cell (
        .x     (a_q[BCD_W-1:0]),
        .y     (b_q[BCD_W-1:0]),
        .c     (carry_q),
        .sub   (sub_q),
        .digit (digit),
        .carry (carry_d)
    );

    assign last  = (idx_q == LAST_IDX);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    // New digit enters at the top; after DIGITS shifts digit 0 reaches the bottom.
    assign s_ins = {digit, s};

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[i*BCD_W +: BCD_W] > BCD_MAX) || (b[i*BCD_W +: BCD_W] > BCD_MAX)) begin
                any_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
                accept    = start;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            // Subtraction is a + nines(b) + 1 - borrow_in.
            carry_q <= sub ? ~cin : cin;
            idx_q   <= '0;
            invalid <= any_bad;
        end else if (state == RUN) begin
            a_q     <= a_q >> BCD_W;
            b_q     <= b_q >> BCD_W;
            carry_q <= carry_d;
            idx_q   <= idx_q + IDX_W'(1);
            s       <= s_ins[W+BCD_W-1:BCD_W];
            if (last) begin
                cout <= carry_d;
            end
        end
    end

endmodule
